// File: rtl/sb_color_scan_ctrl_if.sv
// Byte link from the colour-scan controller to the UART transmitter.
// One byte moves on each clock edge where tx_valid and tx_ready are both high.
interface sb_color_scan_ctrl_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/sb_color_scan_ctrl.sv
// Colour-scan sequencer: settle the sensor, vote over periodic samples, then send a
// three-byte result frame (class, node, '#') over the UART byte link.
module sb_color_scan_ctrl #(
    parameter int unsigned SETTLE_CYC  = 5_000_000,
    parameter int unsigned SAMPLE_CYC  = 500_000,
    parameter int unsigned VOTES       = 3,
    parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
    input  logic                        clk50,
    input  logic                        rst_n,
    input  logic                        scan_req,
    input  logic [7:0]                  node_id,
    input  logic                        sens_done,
    input  logic [7:0]                  sens_msg,
    output logic                        sens_start,
    sb_color_scan_ctrl_if.master        tx,
    output logic                        busy,
    output logic                        scan_ack,
    output logic [7:0]                  scan_result,
    output logic                        scan_fail
);
    localparam int unsigned CNT_W  = 28;
    localparam int unsigned VOTE_W = 3;

    localparam logic [7:0] CLS_D    = 8'h44;
    localparam logic [7:0] CLS_M    = 8'h4D;
    localparam logic [7:0] CLS_W    = 8'h57;
    localparam logic [7:0] CLS_NONE = 8'h4E;
    localparam logic [7:0] FRM_END  = 8'h23;

    typedef enum logic [2:0] {
        IDLE, SETTLE, SAMPLE, GAP, TX_MSG, TX_NODE, TX_END, DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    ph_cnt;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [VOTE_W-1:0]   vote_cnt;
    logic [7:0]          cand;
    logic [7:0]          node_q;
    logic [7:0]          result_q;

    logic                active_c;
    logic                rd_valid_c;
    logic [VOTE_W-1:0]   vote_next_c;
    logic [7:0]          cand_next_c;
    logic                vote_win_c;
    logic                tmo_hit_c;
    logic                to_tx_c;
    logic [7:0]          res_c;

    // Vote bookkeeping for the current sample and the exit decision out of the scan phase.
    always_comb begin
        active_c    = (state == SETTLE) || (state == SAMPLE) || (state == GAP);
        rd_valid_c  = sens_done && ((sens_msg == CLS_D) || (sens_msg == CLS_M) ||
                                    (sens_msg == CLS_W));
        vote_next_c = '0;
        cand_next_c = cand;
        if (rd_valid_c) begin
            if (sens_msg == cand) begin
                vote_next_c = vote_cnt + VOTE_W'(1);
            end else begin
                cand_next_c = sens_msg;
                vote_next_c = VOTE_W'(1);
            end
        end
        vote_win_c = (state == SAMPLE) && (vote_next_c == VOTE_W'(VOTES));
        tmo_hit_c  = active_c && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
        to_tx_c    = vote_win_c || tmo_hit_c;
        res_c      = vote_win_c ? cand_next_c : CLS_NONE;
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            tmo_cnt     <= '0;
            vote_cnt    <= '0;
            cand        <= '0;
            node_q      <= '0;
            result_q    <= '0;
            sens_start  <= 1'b0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= '0;
            busy        <= 1'b0;
            scan_ack    <= 1'b0;
            scan_result <= '0;
            scan_fail   <= 1'b0;
        end else begin
            scan_ack <= 1'b0;
            if (active_c) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                ph_cnt  <= ph_cnt + CNT_W'(1);
            end
            if (state == SAMPLE) begin
                vote_cnt <= vote_next_c;
                cand     <= cand_next_c;
            end

            if (to_tx_c) begin
                // A completed vote in SAMPLE takes precedence over a coincident timeout.
                state       <= TX_MSG;
                result_q    <= res_c;
                scan_fail   <= !vote_win_c;
                sens_start  <= 1'b0;
                tx.tx_valid <= 1'b1;
                tx.tx_data  <= res_c;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan_req) begin
                            state       <= SETTLE;
                            node_q      <= node_id;
                            tmo_cnt     <= '0;
                            ph_cnt      <= '0;
                            vote_cnt    <= '0;
                            busy        <= 1'b1;
                            sens_start  <= 1'b1;
                            scan_result <= '0;
                            scan_fail   <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (ph_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        state  <= GAP;
                        ph_cnt <= '0;
                    end
                    GAP: begin
                        if (ph_cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                            state <= SAMPLE;
                        end
                    end
                    TX_MSG: begin
                        if (tx.tx_ready) begin
                            state      <= TX_NODE;
                            tx.tx_data <= node_q;
                        end
                    end
                    TX_NODE: begin
                        if (tx.tx_ready) begin
                            state      <= TX_END;
                            tx.tx_data <= FRM_END;
                        end
                    end
                    TX_END: begin
                        if (tx.tx_ready) begin
                            state       <= DONE;
                            tx.tx_valid <= 1'b0;
                            tx.tx_data  <= '0;
                            scan_ack    <= 1'b1;
                            scan_result <= result_q;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
                if (state == SETTLE && ph_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    ph_cnt <= '0;
                end
                if (state == GAP && ph_cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                    ph_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_color_scan_ctrl.sv
// Directed bench for sb_color_scan_ctrl with short timing parameters.
// Edge E0 is the edge that starts a scan; samples fall on E11, E16, E21, ...
module tb_sb_color_scan_ctrl;
    logic       clk50 = 1'b0;
    logic       rst_n;
    logic       scan_req;
    logic [7:0] node_id;
    logic       sens_done;
    logic [7:0] sens_msg;
    logic       sens_start;
    logic       busy;
    logic       scan_ack;
    logic [7:0] scan_result;
    logic       scan_fail;

    sb_color_scan_ctrl_if tx_if ();

    sb_color_scan_ctrl #(
        .SETTLE_CYC (10),
        .SAMPLE_CYC (4),
        .VOTES      (3),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .scan_req   (scan_req),
        .node_id    (node_id),
        .sens_done  (sens_done),
        .sens_msg   (sens_msg),
        .sens_start (sens_start),
        .tx         (tx_if),
        .busy       (busy),
        .scan_ack   (scan_ack),
        .scan_result(scan_result),
        .scan_fail  (scan_fail)
    );

    always #10 clk50 = ~clk50;

    int         total = 0;
    int         bad = 0;
    int         n;
    int         first_valid;
    int         ack_cnt;
    logic [7:0] frame[$];
    logic [7:0] res_at_ack;
    logic       fail_at_ack;
    logic       stall_bad;
    logic       over_budget;
    logic       nz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int i);
        return (frame.size() > i) ? frame[i] : 8'hFF;
    endfunction

    // Class presented for sample k under each stimulus mode.
    function automatic logic [7:0] pat(input int mode, input int k);
        case (mode)
            1:       return (k % 2 == 0) ? 8'h44 : 8'h57;
            2:       return (k < 2) ? 8'h44 : 8'h57;
            default: return 8'h4D;
        endcase
    endfunction

    task automatic start_scan(input logic [7:0] nid, input int mode);
        @(negedge clk50);
        node_id  = nid;
        sens_msg = pat(mode, 0);
        scan_req = 1'b1;
        @(negedge clk50);
        scan_req = 1'b0;
        n        = 0;
    endtask

    // Steps negedge by negedge until the scan has acked and busy has dropped.
    task automatic run_scan(input int mode, input logic [7:0] nid);
        int stall_left = 0;
        bit stalled    = 1'b0;
        bit done       = 1'b0;
        frame.delete();
        first_valid = -1;
        ack_cnt     = 0;
        stall_bad   = 1'b0;
        over_budget = 1'b0;
        while (!done) begin
            if (tx_if.tx_valid === 1'b1 && first_valid < 0) first_valid = n;
            if (scan_ack === 1'b1) begin
                ack_cnt++;
                res_at_ack  = scan_result;
                fail_at_ack = scan_fail;
            end
            if (mode == 3 && !stalled && frame.size() == 1) begin
                stalled          = 1'b1;
                stall_left       = 21;
                tx_if.tx_ready   = 1'b0;
            end
            if (stall_left > 0) begin
                if (!(tx_if.tx_valid === 1'b1 && tx_if.tx_data === nid)) stall_bad = 1'b1;
                stall_left--;
                if (stall_left == 0) tx_if.tx_ready = 1'b1;
            end
            if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) frame.push_back(tx_if.tx_data);
            sens_msg = pat(mode, (n + 1 <= 11) ? 0 : (n + 1 - 11 + 4) / 5);
            if (ack_cnt > 0 && busy === 1'b0) begin
                done = 1'b1;
            end else if (n > 400) begin
                over_budget = 1'b1;
                done        = 1'b1;
            end else begin
                @(negedge clk50);
                n++;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        scan_req       = 1'b0;
        node_id        = 8'h00;
        sens_done      = 1'b0;
        sens_msg       = 8'h00;
        tx_if.tx_ready = 1'b1;

        // Reset and quiet idle.
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        nz    = 1'b0;
        repeat (20) begin
            @(negedge clk50);
            nz = nz | sens_start | busy | scan_ack | scan_fail | tx_if.tx_valid |
                 (|scan_result) | (|tx_if.tx_data);
        end
        chk("rst_quiet", 32'(nz), 0);
        chk("rst_sens_start", 32'(sens_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_valid", 32'(tx_if.tx_valid), 0);
        chk("rst_scan_result", 32'(scan_result), 0);
        chk("rst_scan_fail", 32'(scan_fail), 0);

        // Constant 'M': accepted at the third sample (E21).
        sens_done = 1'b1;
        start_scan(8'h05, 0);
        chk("t2_sens_start", 32'(sens_start), 1);
        chk("t2_busy", 32'(busy), 1);
        run_scan(0, 8'h05);
        chk("t2_budget", 32'(over_budget), 0);
        chk("t2_first_valid", 32'(first_valid), 21);
        chk("t2_nbytes", 32'(frame.size()), 3);
        chk("t2_b0", 32'(fbyte(0)), 32'h4D);
        chk("t2_b1", 32'(fbyte(1)), 32'h05);
        chk("t2_b2", 32'(fbyte(2)), 32'h23);
        chk("t2_ack_cnt", 32'(ack_cnt), 1);
        chk("t2_result", 32'(res_at_ack), 32'h4D);
        chk("t2_fail", 32'(fail_at_ack), 0);
        chk("t2_result_held", 32'(scan_result), 32'h4D);

        // Alternating D/W: no vote completes, timeout frame at E100.
        start_scan(8'h0A, 1);
        run_scan(1, 8'h0A);
        chk("t3_budget", 32'(over_budget), 0);
        chk("t3_first_valid", 32'(first_valid), 100);
        chk("t3_b0", 32'(fbyte(0)), 32'h4E);
        chk("t3_b1", 32'(fbyte(1)), 32'h0A);
        chk("t3_b2", 32'(fbyte(2)), 32'h23);
        chk("t3_result", 32'(scan_result), 32'h4E);
        chk("t3_fail", 32'(scan_fail), 1);

        // D,D,W,W,W: candidate restarts at the first W, accepted at the fifth sample (E31).
        start_scan(8'h0C, 2);
        chk("t4_fail_cleared", 32'(scan_fail), 0);
        chk("t4_result_cleared", 32'(scan_result), 0);
        run_scan(2, 8'h0C);
        chk("t4_budget", 32'(over_budget), 0);
        chk("t4_first_valid", 32'(first_valid), 31);
        chk("t4_b0", 32'(fbyte(0)), 32'h57);
        chk("t4_result", 32'(res_at_ack), 32'h57);

        // Back-pressure on the node byte for 20 cycles.
        start_scan(8'h77, 3);
        run_scan(3, 8'h77);
        chk("t5_budget", 32'(over_budget), 0);
        chk("t5_stall_stable", 32'(stall_bad), 0);
        chk("t5_nbytes", 32'(frame.size()), 3);
        chk("t5_b1", 32'(fbyte(1)), 32'h77);
        chk("t5_b2", 32'(fbyte(2)), 32'h23);

        // Reset in TX_MSG aborts at once; the next scan runs from SETTLE.
        start_scan(8'h31, 0);
        for (int i = 0; i < 200 && tx_if.tx_valid !== 1'b1; i++) @(negedge clk50);
        chk("t6_in_tx", 32'(tx_if.tx_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", 32'(tx_if.tx_valid), 0);
        chk("t6_busy_drop", 32'(busy), 0);
        chk("t6_sens_start_drop", 32'(sens_start), 0);
        repeat (2) @(negedge clk50);
        rst_n = 1'b1;
        start_scan(8'h22, 0);
        chk("t6_restart_sens_start", 32'(sens_start), 1);
        run_scan(0, 8'h22);
        chk("t6_budget", 32'(over_budget), 0);
        chk("t6_first_valid", 32'(first_valid), 21);
        chk("t6_nbytes", 32'(frame.size()), 3);
        chk("t6_b0", 32'(fbyte(0)), 32'h4D);
        chk("t6_b1", 32'(fbyte(1)), 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
